// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory request/response port plus
// the instruction buffer write interface, as seen by fetch_ctrl.
interface fetch_ctrl_if;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        buf_stall;
    logic        buf_clear;
    logic        buf_align;
    logic [31:0] buf_pc;
    logic [31:0] buf_rdata;
    logic        buf_ready;

    modport master (
        output imem_valid, imem_addr,
        input  imem_ready, imem_rdata,
        input  buf_stall,
        output buf_clear, buf_align, buf_pc, buf_rdata, buf_ready
    );

    modport slave (
        input  imem_valid, imem_addr,
        output imem_ready, imem_rdata,
        output buf_stall,
        input  buf_clear, buf_align, buf_pc, buf_rdata, buf_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: single-outstanding word fetches into a
// one-entry hold, delivered to the instruction buffer; redirects flush.
module fetch_ctrl #(
    parameter logic [31:0] start_addr = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;

    state_t      state, state_nx;
    logic [31:0] fpc;
    logic [31:0] req_pc;
    logic        hold_v;
    logic [31:0] hold_pc;
    logic [31:0] hold_data;
    logic        stall_q;

    logic redir;
    logic present;
    logic free;
    logic issue;
    logic capture;

    assign redir   = redirect_valid & reset;
    assign present = hold_v & ~stall_q & ~redir & reset;
    assign free    = ~hold_v | present;
    assign issue   = (state == ISSUE) & free & ~redir & reset;
    assign capture = (state == WAIT) & bus.imem_ready & ~redir;

    assign bus.imem_valid = issue;
    assign bus.imem_addr  = issue ? fpc : 32'h0;
    assign bus.buf_clear  = redir;
    assign bus.buf_align  = redir & redirect_pc[1];
    assign bus.buf_ready  = present;
    assign bus.buf_pc     = present ? hold_pc : 32'h0;
    assign bus.buf_rdata  = present ? hold_data : 32'h0;

    // NOTE: state_nx gets its default first so every path assigns it and no latch is inferred.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = ISSUE;
            ISSUE: if (issue) state_nx = WAIT;
            WAIT:  if (bus.imem_ready) state_nx = ISSUE;
            FLUSH: if (bus.imem_ready) state_nx = ISSUE;
        endcase
        // A redirect suppresses imem_valid, so from IDLE/ISSUE nothing is in
        // flight; only a still-pending response forces the FLUSH detour.
        if (redir) begin
            if (((state == WAIT) || (state == FLUSH)) && !bus.imem_ready)
                state_nx = FLUSH;
            else
                state_nx = ISSUE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            fpc       <= start_addr & ~32'd3;
            req_pc    <= 32'h0;
            hold_v    <= 1'b0;
            hold_pc   <= 32'h0;
            hold_data <= 32'h0;
            stall_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            stall_q <= bus.buf_stall;

            if (redir)
                fpc <= redirect_pc & ~32'd3;
            else if (issue)
                fpc <= fpc + 32'd4;

            if (issue)
                req_pc <= fpc;

            if (redir)
                hold_v <= 1'b0;
            else if (capture)
                hold_v <= 1'b1;
            else if (present)
                hold_v <= 1'b0;

            if (capture) begin
                hold_pc   <= req_pc;
                hold_data <= bus.imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected requests and buffer words are
// queued up front; monitors pop and compare whenever the DUT presents one.
module tb_fetch_ctrl;

    typedef struct {
        logic [31:0] addr;
        int          gap;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } bw_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    fetch_ctrl_if ifc ();

    fetch_ctrl #(.start_addr(32'h0000_0100)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (ifc)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mem_lat = 1;

    req_t exp_req[$];
    bw_t  exp_buf[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Memory model: responds mem_lat cycles after the request edge with addr ^ C0DE0000.
    initial begin
        logic        seen;
        logic [31:0] a, pend;
        int          cnt;
        ifc.imem_ready = 1'b0;
        ifc.imem_rdata = 32'h0;
        cnt  = 0;
        pend = 32'h0;
        forever begin
            @(negedge clock);
            seen = ifc.imem_valid;
            a    = ifc.imem_addr;
            @(posedge clock);
            #1;
            ifc.imem_ready = 1'b0;
            ifc.imem_rdata = 32'h0;
            if (seen) begin
                pend = a;
                cnt  = mem_lat;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ifc.imem_ready = 1'b1;
                    ifc.imem_rdata = pend ^ 32'hC0DE_0000;
                end
            end
        end
    end

    // Request monitor.
    initial begin
        int   last = 0;
        req_t r;
        forever begin
            @(negedge clock);
            if (ifc.imem_valid) begin
                if (exp_req.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_req: got %h, want none", ifc.imem_addr);
                end else begin
                    r = exp_req.pop_front();
                    check("imem_addr", ifc.imem_addr, r.addr);
                    if (r.gap != 0) check("req_gap", 32'(cyc - last), 32'(r.gap));
                end
                last = cyc;
            end
        end
    end

    // Buffer monitor.
    initial begin
        bw_t w;
        forever begin
            @(negedge clock);
            if (ifc.buf_ready) begin
                if (exp_buf.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_buf: got %h, want none", ifc.buf_pc);
                end else begin
                    w = exp_buf.pop_front();
                    check("buf_pc", ifc.buf_pc, w.pc);
                    check("buf_rdata", ifc.buf_rdata, w.data);
                end
            end
        end
    end

    task automatic wait_req(input logic [31:0] addr);
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (ifc.imem_valid && ifc.imem_addr == addr) return;
        end
        check("wait_req_timeout", 32'h0, addr);
    endtask

    task automatic wait_buf(input logic [31:0] pc);
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (ifc.buf_ready && ifc.buf_pc == pc) return;
        end
        check("wait_buf_timeout", 32'h0, pc);
    endtask

    task automatic wait_rsp(input logic [31:0] data);
        for (int i = 0; i < 60; i++) begin
            step();
            if (ifc.imem_ready && ifc.imem_rdata == data) return;
        end
        check("wait_rsp_timeout", 32'h0, data);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_valid"}, 32'(ifc.imem_valid), 32'h0);
        check({tag, "_imem_addr"},  ifc.imem_addr,       32'h0);
        check({tag, "_buf_clear"},  32'(ifc.buf_clear),  32'h0);
        check({tag, "_buf_align"},  32'(ifc.buf_align),  32'h0);
        check({tag, "_buf_pc"},     ifc.buf_pc,          32'h0);
        check({tag, "_buf_rdata"},  ifc.buf_rdata,       32'h0);
        check({tag, "_buf_ready"},  32'(ifc.buf_ready),  32'h0);
    endtask

    initial begin
        // Whole-run expected streams, in order.
        exp_req.push_back('{32'h0000_0100, 0});
        exp_req.push_back('{32'h0000_0104, 2});
        exp_req.push_back('{32'h0000_0108, 0});
        exp_req.push_back('{32'h0000_0200, 0});
        exp_req.push_back('{32'h0000_0204, 4});
        exp_req.push_back('{32'h0000_0500, 0});
        exp_req.push_back('{32'h0000_0400, 0});
        exp_req.push_back('{32'h0000_0404, 0});
        exp_req.push_back('{32'hFFFF_FFFC, 0});
        exp_req.push_back('{32'h0000_0000, 5});
        exp_req.push_back('{32'h0000_0004, 0});
        exp_req.push_back('{32'h0000_0100, 0});
        exp_req.push_back('{32'h0000_0104, 0});
        exp_buf.push_back('{32'h0000_0100, 32'hC0DE_0100});
        exp_buf.push_back('{32'h0000_0104, 32'hC0DE_0104});
        exp_buf.push_back('{32'h0000_0200, 32'hC0DE_0200});
        exp_buf.push_back('{32'h0000_0400, 32'hC0DE_0400});
        exp_buf.push_back('{32'hFFFF_FFFC, 32'h3F21_FFFC});
        exp_buf.push_back('{32'h0000_0000, 32'hC0DE_0000});
        exp_buf.push_back('{32'h0000_0100, 32'hC0DE_0100});

        ifc.buf_stall = 1'b0;
        repeat (3) step();
        @(negedge clock);
        check_all_zero("reset");
        step();
        reset = 1'b1;
        @(negedge clock);
        check("idle_cycle_imem_valid", 32'(ifc.imem_valid), 32'h0);

        // Stall while 0x104 sits in the hold.
        wait_rsp(32'hC0DE_0104);
        ifc.buf_stall = 1'b1;
        mem_lat = 3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("stall_imem_valid", 32'(ifc.imem_valid), 32'h0);
            check("stall_buf_ready", 32'(ifc.buf_ready), 32'h0);
        end
        step();
        ifc.buf_stall = 1'b0;

        // Redirect to 0x202 while waiting on 0x108.
        wait_req(32'h0000_0108);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0202;
        @(negedge clock);
        check("redir1_buf_clear", 32'(ifc.buf_clear), 32'h1);
        check("redir1_buf_align", 32'(ifc.buf_align), 32'h1);
        check("redir1_imem_valid", 32'(ifc.imem_valid), 32'h0);
        step();
        redirect_valid = 1'b0;

        // Redirect coincident with the 0x204 response.
        wait_rsp(32'hC0DE_0204);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0500;
        mem_lat = 5;
        @(negedge clock);
        check("redir2_buf_clear", 32'(ifc.buf_clear), 32'h1);
        check("redir2_buf_align", 32'(ifc.buf_align), 32'h0);
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        check("redir2_no_flush_valid", 32'(ifc.imem_valid), 32'h1);
        check("redir2_no_flush_addr", ifc.imem_addr, 32'h0000_0500);

        // Two redirects during a latency-5 response.
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        @(negedge clock);
        check("redir3_buf_clear", 32'(ifc.buf_clear), 32'h1);
        check("redir3_buf_align", 32'(ifc.buf_align), 32'h0);
        step();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0400;
        @(negedge clock);
        check("redir4_buf_clear", 32'(ifc.buf_clear), 32'h1);
        check("redir4_buf_align", 32'(ifc.buf_align), 32'h0);
        step();
        redirect_valid = 1'b0;

        // Wrap from 0xFFFFFFFC; bit 0 of the target is ignored.
        wait_buf(32'h0000_0400);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        mem_lat = 4;
        @(negedge clock);
        check("redir5_buf_align", 32'(ifc.buf_align), 32'h1);
        step();
        redirect_valid = 1'b0;

        // Reset in the middle of the 0x4 request.
        wait_req(32'h0000_0004);
        step();
        step();
        reset = 1'b0;
        step();
        @(negedge clock);
        check_all_zero("midreset");
        step();
        reset = 1'b1;
        @(negedge clock);
        check("late_ready_buf_ready", 32'(ifc.buf_ready), 32'h0);

        for (int i = 0; i < 60; i++) begin
            if (exp_req.size() == 0 && exp_buf.size() == 0) break;
            @(negedge clock);
        end
        reset = 1'b0;
        repeat (3) step();
        check("req_queue_drained", 32'(exp_req.size()), 32'h0);
        check("buf_queue_drained", 32'(exp_buf.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
